// File: rtl/fetch_loader_ctrl_pkg.sv
// Shared definitions for the fetch loader controller: host command codes,
// the halt opcode, the load size limit and the controller state encoding.
`timescale 1ns/1ps
package fetch_loader_ctrl_pkg;

    // Host command bytes, recognised while IDLE or HALTED (STOP also in RUN/STEP).
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_STOP = 8'h04;

    // Top six instruction bits that mark a HALT instruction.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // Instruction memory depth in words; larger load counts are clamped to this.
    localparam int unsigned MAX_WORDS = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_DATA = 3'd2,
        WRITE     = 3'd3,
        PC_CLR    = 3'd4,
        RUN       = 3'd5,
        STEP      = 3'd6,
        HALTED    = 3'd7
    } state_e;

    // Word count received from the host, clamped to the memory depth.
    function automatic logic [5:0] clamp_count(input logic [7:0] n);
        return (n > 8'(MAX_WORDS)) ? 6'(MAX_WORDS) : 6'(n);
    endfunction

endpackage

// File: rtl/fetch_loader_ctrl_byte_to_word.sv
// byte_to_word: assembles received bytes into an instruction word, first
// byte in the most significant position.
// Ports:
//   clock_i, reset_i  clock and synchronous active-high reset
//   clear_i           drops any partially assembled word
//   byte_valid_i      qualifies byte_i
//   byte_i            incoming byte
//   word_o            assembled word including the byte currently offered
//   word_valid_o      high for the single cycle in which the last byte is offered
`timescale 1ns/1ps
module byte_to_word #(
    parameter int NB_DATA = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic [NB_DATA-1:0] word_o,
    output logic               word_valid_o
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    // Only the earlier bytes need storage; the final byte is taken straight
    // from the input so the word is complete in the cycle it arrives.
    logic [NB_DATA-9:0] shift_q;
    logic [NB_CNT-1:0]  cnt_q;

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == NB_CNT'(NB_BYTES - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= word_o[NB_DATA-9:0];
            cnt_q   <= word_valid_o ? '0 : cnt_q + NB_CNT'(1);
        end
    end

endmodule

// File: rtl/fetch_loader_ctrl.sv
// fetch_loader_ctrl: receives host command bytes, loads instruction memory
// word by word, and starts, single-steps or stops the fetch stage. A fetched
// HALT instruction parks the controller in HALTED.
// Ports:
//   clock_i, reset_i   clock and synchronous active-high reset
//   rx_data_i/valid_i  received byte and its one-cycle strobe
//   instruction_i      word returned by the fetch stage
//   fetch_reset_o      fetch stage reset (PC clear)
//   fetch_enable_o     fetch stage PC enable
//   mem_en_read_o      instruction memory read enable
//   mem_en_write_o     instruction memory write strobe
//   mem_addr_o         write byte address
//   mem_data_o         write data
//   halted_o           high while halted
//   busy_o             high in every state except IDLE and HALTED
// Bytes are accepted only on rx_valid_i; bytes arriving during WRITE or
// PC_CLR are dropped, so the sender spaces bytes by at least two cycles.
`timescale 1ns/1ps
module fetch_loader_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    input  logic [NB_DATA-1:0] instruction_i,
    output logic               fetch_reset_o,
    output logic               fetch_enable_o,
    output logic               mem_en_read_o,
    output logic               mem_en_write_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0] mem_data_o,
    output logic               halted_o,
    output logic               busy_o
);

    import fetch_loader_ctrl_pkg::*;

    state_e       state_q, state_d;
    logic [5:0]   n_words_q, n_words_d;
    logic [5:0]   word_idx_q, word_idx_d;
    logic         step_mode_q, step_mode_d;
    logic         step_pulse_d;
    logic         mem_read_q;
    logic         halt_hit;

    logic [NB_DATA-1:0] word;
    logic               word_valid;

    // Only the opcode field matters for halt detection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction_i[NB_DATA-7:0];

    byte_to_word #(.NB_DATA(NB_DATA)) u_byte_to_word (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (state_q != LOAD_DATA),
        .byte_valid_i (rx_valid_i && (state_q == LOAD_DATA)),
        .byte_i       (rx_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // instruction_i answers the read issued one cycle earlier, so it is only
    // trusted when the read enable was high in the previous cycle.
    assign halt_hit = ((state_q == RUN) || (state_q == STEP)) && mem_read_q &&
                      (instruction_i[NB_DATA-1 -: 6] == HALT_OPCODE);

    always_comb begin
        state_d      = state_q;
        n_words_d    = n_words_q;
        word_idx_d   = word_idx_q;
        step_mode_d  = step_mode_q;
        step_pulse_d = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (rx_valid_i) begin
                    case (rx_data_i)
                        CMD_LOAD: state_d = LOAD_CNT;
                        CMD_RUN: begin
                            state_d     = PC_CLR;
                            step_mode_d = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d     = PC_CLR;
                            step_mode_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_CNT: begin
                if (rx_valid_i) begin
                    word_idx_d = '0;
                    n_words_d  = clamp_count(rx_data_i);
                    state_d    = (rx_data_i == 8'h00) ? IDLE : LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                word_idx_d = word_idx_q + 6'd1;
                state_d    = (word_idx_d == n_words_q) ? IDLE : LOAD_DATA;
            end
            PC_CLR: begin
                state_d = step_mode_q ? STEP : RUN;
            end
            RUN: begin
                // Halt takes priority over a simultaneous stop byte.
                if (halt_hit)
                    state_d = HALTED;
                else if (rx_valid_i && (rx_data_i == CMD_STOP))
                    state_d = IDLE;
            end
            STEP: begin
                if (halt_hit)
                    state_d = HALTED;
                else if (rx_valid_i && (rx_data_i == CMD_STOP))
                    state_d = IDLE;
                else if (rx_valid_i && (rx_data_i == CMD_STEP))
                    step_pulse_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            n_words_q      <= '0;
            word_idx_q     <= '0;
            step_mode_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            fetch_reset_o  <= 1'b1;
            fetch_enable_o <= 1'b0;
            mem_en_read_o  <= 1'b0;
            mem_en_write_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            halted_o       <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_words_q      <= n_words_d;
            word_idx_q     <= word_idx_d;
            step_mode_q    <= step_mode_d;
            mem_read_q     <= mem_en_read_o;
            fetch_reset_o  <= (state_d == PC_CLR);
            fetch_enable_o <= (state_d == RUN) || step_pulse_d;
            mem_en_read_o  <= (state_d == RUN) || (state_d == STEP);
            mem_en_write_o <= (state_d == WRITE);
            mem_addr_o     <= (state_d == WRITE) ? NB_ADDR'({word_idx_q, 2'b00}) : '0;
            mem_data_o     <= (state_d == WRITE) ? word : '0;
            halted_o       <= (state_d == HALTED);
            busy_o         <= (state_d != IDLE) && (state_d != HALTED);
        end
    end

endmodule

// File: doc/fetch_loader_ctrl.md
FETCH_LOADER_CTRL -- requirements
Module: fetch_loader_ctrl

Interface
REQ-001 Parameter NB_DATA, 32, instruction word width.
REQ-002 Parameter NB_ADDR, 7, instruction memory byte-address width.
REQ-003 clock_i  in  1  single clock; all logic on rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 rx_data_i  in  8  received byte.
REQ-006 rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
REQ-007 instruction_i  in  NB_DATA  word read from the fetch stage.
REQ-008 fetch_reset_o  out  1  drives the fetch stage reset.
REQ-009 fetch_enable_o  out  1  drives the fetch stage PC enable.
REQ-010 mem_en_read_o  out  1  instruction memory read enable.
REQ-011 mem_en_write_o  out  1  instruction memory write strobe.
REQ-012 mem_addr_o  out  NB_ADDR  instruction memory write byte address.
REQ-013 mem_data_o  out  NB_DATA  instruction memory write data.
REQ-014 halted_o  out  1  high while in HALTED.
REQ-015 busy_o  out  1  high in every state except IDLE and HALTED.

Function
REQ-016 States: IDLE, LOAD_CNT, LOAD_DATA, WRITE, PC_CLR, RUN, STEP, HALTED.
REQ-017 IDLE/HALTED, rx byte 0x01 -> LOAD_CNT; 0x02 -> PC_CLR then RUN; 0x03 -> PC_CLR then STEP; any other byte ignored.
REQ-018 LOAD_CNT: next byte N = word count; N=0 -> IDLE with no write; N>32 clamps to 32; the word index and byte counter clear.
REQ-019 LOAD_DATA: bytes are assembled MSB first; the 4th byte moves to WRITE.
REQ-020 WRITE lasts exactly 1 cycle, with mem_en_write_o=1, mem_addr_o=4*word_index, mem_data_o=assembled word; word_index then increments.
REQ-021 After WRITE: if word_index==N -> IDLE, else -> LOAD_DATA.
REQ-022 Word index 31 maps to address 124, the last address; no wrap-around occurs because N<=32.
REQ-023 rx_valid_i in WRITE or PC_CLR is dropped; the sender must space bytes by at least 2 cycles.
REQ-024 PC_CLR lasts exactly 1 cycle, with fetch_reset_o=1 and fetch_enable_o=0.
REQ-025 RUN: fetch_enable_o=1 and mem_en_read_o=1 every cycle.
REQ-026 STEP: mem_en_read_o=1; each rx byte 0x03 gives exactly one cycle of fetch_enable_o=1; byte 0x04 -> IDLE.
REQ-027 RUN, rx byte 0x04 -> IDLE; fetch_enable_o drops on the next cycle.
REQ-028 Halt: in RUN or STEP, if mem_en_read_o was high in the prior cycle and instruction_i[31:26]==6'b111111 -> HALTED, with fetch_enable_o=0 from that cycle on.
REQ-029 If halt and the 0x04 stop byte occur in the same cycle, halt wins.
REQ-030 HALTED: outputs are as in IDLE except halted_o=1; PC and memory are untouched.
REQ-031 mem_en_write_o is never high outside WRITE; fetch_enable_o is never high outside RUN or STEP.

Reset
REQ-032 reset_i=1 at a rising edge -> IDLE; word_index, byte counter, N and the assembly register are 0.
REQ-033 During and after reset, every output is 0 except fetch_reset_o=1 while reset_i=1.
REQ-034 Reset asserted mid-load or mid-run aborts the operation; a partially assembled word is not written.

Structure
REQ-035 A shared package holds: command codes (0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 STOP), HALT_OPCODE=6'b111111, MAX_WORDS=32, and the state enumeration.
REQ-036 One sub-module, byte_to_word, holds the 4-byte shift register and byte counter and raises word_valid for 1 cycle.
REQ-037 The FSM and counters live in fetch_loader_ctrl; all outputs are registered.

Verification
REQ-038 Load: bytes 01,02,AA,BB,CC,DD,11,22,33,44 -> writes of 0xAABBCCDD at addr 0 and 0x11223344 at addr 4, then IDLE.
REQ-039 Boundaries: load with N=0 -> no write, IDLE; load with N=40 -> exactly 32 writes, the last at addr 124.
REQ-040 Run: load 3 words with word 2=0xFC000000, then byte 02 -> fetch_reset_o pulses 1 cycle, enable runs, halted_o=1 after the HALT word is read.
REQ-041 Step: byte 03 then three 03 bytes -> exactly 3 single-cycle fetch_enable_o pulses; byte 04 -> IDLE.
REQ-042 Stop: byte 04 during RUN -> IDLE; same cycle as HALT -> HALTED.
REQ-043 Mid-operation reset: reset_i after 2 of 4 data bytes -> no write, IDLE, all outputs 0.
